// File: rtl/axi_wr_arbiter_if.sv
// Bundled AW/W request, arbitrated output and W-routing status signals of axi_wr_arbiter.
// The slave modport is the arbiter's view; master is the environment that drives it.
interface axi_wr_arbiter_if #(
  parameter int NumInp   = 4,
  parameter int MaxWTxns = 4,
  parameter int AwWidth  = 64,
  parameter int WWidth   = 72
);
  localparam int IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int CntW = $clog2(MaxWTxns + 1);

  logic [NumInp-1:0]         inp_aw_valid_i;
  logic [NumInp*AwWidth-1:0] inp_aw_i;
  logic [NumInp-1:0]         inp_aw_ready_o;
  logic                      oup_aw_valid_o;
  logic [AwWidth-1:0]        oup_aw_o;
  logic [IdxW-1:0]           oup_aw_idx_o;
  logic                      oup_aw_ready_i;

  logic [NumInp-1:0]         inp_w_valid_i;
  logic [NumInp*WWidth-1:0]  inp_w_i;
  logic [NumInp-1:0]         inp_w_last_i;
  logic [NumInp-1:0]         inp_w_ready_o;
  logic                      oup_w_valid_o;
  logic [WWidth-1:0]         oup_w_o;
  logic                      oup_w_last_o;
  logic                      oup_w_ready_i;

  logic [CntW-1:0]           w_pending_o;

  modport slave (
    input  inp_aw_valid_i, inp_aw_i, oup_aw_ready_i,
    input  inp_w_valid_i, inp_w_i, inp_w_last_i, oup_w_ready_i,
    output inp_aw_ready_o, oup_aw_valid_o, oup_aw_o, oup_aw_idx_o,
    output inp_w_ready_o, oup_w_valid_o, oup_w_o, oup_w_last_o,
    output w_pending_o
  );

  modport master (
    output inp_aw_valid_i, inp_aw_i, oup_aw_ready_i,
    output inp_w_valid_i, inp_w_i, inp_w_last_i, oup_w_ready_i,
    input  inp_aw_ready_o, oup_aw_valid_o, oup_aw_o, oup_aw_idx_o,
    input  inp_w_ready_o, oup_w_valid_o, oup_w_o, oup_w_last_o,
    input  w_pending_o
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin AW arbiter (0-cycle AW path) with an index queue that routes W bursts in AW order.
// W of a granted AW is usable one cycle after its handshake; AW stalls while the index queue is full.
module axi_wr_arbiter #(
  parameter int NumInp   = 4,
  parameter int MaxWTxns = 4,
  parameter int AwWidth  = 64,
  parameter int WWidth   = 72
) (
  input logic           clk_i,
  input logic           rst_i,
  axi_wr_arbiter_if.slave bus
);
  localparam int IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int CntW = $clog2(MaxWTxns + 1);
  localparam int PtrW = (MaxWTxns > 1) ? $clog2(MaxWTxns) : 1;

  logic [IdxW-1:0]    rr_ptr;
  logic               lock_q;
  logic [IdxW-1:0]    lock_idx;
  logic [IdxW-1:0]    search_idx;
  logic [IdxW-1:0]    search_cand;
  logic [IdxW-1:0]    grant;
  logic [IdxW-1:0]    next_rr;
  logic [IdxW-1:0]    idx_q [MaxWTxns];
  logic [PtrW-1:0]    wr_ptr;
  logic [PtrW-1:0]    rd_ptr;
  logic [CntW-1:0]    count;
  logic [IdxW-1:0]    head;
  logic               queue_full;
  logic               queue_empty;
  logic               aw_valid;
  logic               aw_hs;
  logic               w_valid;
  logic               w_last;
  logic               w_pop;
  logic [NumInp-1:0]  aw_ready;
  logic [NumInp-1:0]  w_ready;
  logic [AwWidth-1:0] aw_arr [NumInp];
  logic [WWidth-1:0]  w_arr  [NumInp];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (int'(p) == MaxWTxns - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      aw_arr[i] = bus.inp_aw_i[i*AwWidth +: AwWidth];
      w_arr[i]  = bus.inp_w_i[i*WWidth +: WWidth];
    end
  end

  // Walk offsets from high to low so the closest valid at/after rr_ptr wins.
  always_comb begin
    search_idx  = rr_ptr;
    search_cand = rr_ptr;
    for (int i = NumInp - 1; i >= 0; i--) begin
      search_cand = IdxW'((int'(rr_ptr) + i) % NumInp);
      if (bus.inp_aw_valid_i[search_cand]) search_idx = search_cand;
    end
  end

  assign grant       = lock_q ? lock_idx : search_idx;
  assign next_rr     = (int'(grant) == NumInp - 1) ? '0 : grant + 1'b1;
  assign queue_full  = (count == CntW'(MaxWTxns));
  assign queue_empty = (count == '0);
  assign aw_valid    = (|bus.inp_aw_valid_i) & ~queue_full;
  assign aw_hs       = aw_valid & bus.oup_aw_ready_i;

  always_comb begin
    aw_ready        = '0;
    aw_ready[grant] = bus.oup_aw_ready_i & ~queue_full;
  end

  assign head    = idx_q[rd_ptr];
  assign w_valid = ~queue_empty & bus.inp_w_valid_i[head];
  assign w_last  = ~queue_empty & bus.inp_w_last_i[head];
  assign w_pop   = w_valid & w_last & bus.oup_w_ready_i;

  always_comb begin
    w_ready       = '0;
    w_ready[head] = bus.oup_w_ready_i & ~queue_empty;
  end

  assign bus.oup_aw_valid_o = aw_valid;
  assign bus.oup_aw_o       = aw_arr[grant];
  assign bus.oup_aw_idx_o   = grant;
  assign bus.inp_aw_ready_o = aw_ready;
  assign bus.oup_w_valid_o  = w_valid;
  assign bus.oup_w_o        = w_arr[head];
  assign bus.oup_w_last_o   = w_last;
  assign bus.inp_w_ready_o  = w_ready;
  assign bus.w_pending_o    = count;

  // A stalled AW keeps its grant; a full queue leaves the lock untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      lock_q   <= 1'b0;
      lock_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < MaxWTxns; i++) idx_q[i] <= '0;
    end else begin
      if (aw_hs) begin
        lock_q        <= 1'b0;
        rr_ptr        <= next_rr;
        idx_q[wr_ptr] <= grant;
        wr_ptr        <= ptr_inc(wr_ptr);
      end else if (aw_valid) begin
        lock_q   <= 1'b1;
        lock_idx <= grant;
      end
      if (w_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (aw_hs && !w_pop)      count <= count + 1'b1;
      else if (!aw_hs && w_pop) count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: round-robin order, grant lock, queue-full stall, W ordering, reset.
module tb_axi_wr_arbiter;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int WW = 72;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   bt [N];

  axi_wr_arbiter_if #(.NumInp(N), .MaxWTxns(4), .AwWidth(AW), .WWidth(WW)) bus ();

  axi_wr_arbiter #(.NumInp(N), .MaxWTxns(4), .AwWidth(AW), .WWidth(WW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [AW-1:0] aw_pat(input int i);
    return {32'hA11CE000, 32'(i)};
  endfunction

  function automatic logic [WW-1:0] w_pat(input int i, input int b);
    return {8'(i), 32'hBEEF0000, 32'(b)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_w(input logic [N-1:0] v, input logic force_last);
    bus.inp_w_valid_i = v;
    for (int i = 0; i < N; i++) begin
      bus.inp_w_i[i*WW +: WW] = w_pat(i, bt[i]);
      bus.inp_w_last_i[i]     = force_last | (bt[i] == 3);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.inp_aw_valid_i = '0;
    bus.oup_aw_ready_i = 1'b0;
    bus.oup_w_ready_i  = 1'b0;
    for (int i = 0; i < N; i++) bt[i] = 0;
    drive_w('0, 1'b0);
    adv();
    adv();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) bus.inp_aw_i[i*AW +: AW] = aw_pat(i);
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_w_pending", 128'(bus.w_pending_o), 128'd0);
    chk("rst_aw_valid", 128'(bus.oup_aw_valid_o), 128'd0);
    chk("rst_w_valid", 128'(bus.oup_w_valid_o), 128'd0);
    chk("rst_w_ready", 128'(bus.inp_w_ready_o), 128'd0);
    chk("rst_aw_ready", 128'(bus.inp_aw_ready_o), 128'd0);
    adv();

    // All inputs requesting: grants rotate 0,1,2,3,0; single-beat W drains behind.
    bus.inp_aw_valid_i = 4'hF;
    bus.oup_aw_ready_i = 1'b1;
    bus.oup_w_ready_i  = 1'b1;
    drive_w(4'hF, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_idx", 128'(bus.oup_aw_idx_o), 128'(k % 4));
      chk("rr_payload", 128'(bus.oup_aw_o), 128'(aw_pat(k % 4)));
      chk("rr_aw_ready", 128'(bus.inp_aw_ready_o), 128'(4'b1 << (k % 4)));
      chk("rr_w_valid", 128'(bus.oup_w_valid_o), 128'(k > 0));
      if (k > 0) chk("rr_w_data", 128'(bus.oup_w_o), 128'(w_pat((k - 1) % 4, 0)));
      adv();
    end
    bus.inp_aw_valid_i = '0;
    @(negedge clk);
    chk("rr_pending_tail", 128'(bus.w_pending_o), 128'd1);
    chk("rr_w_tail", 128'(bus.oup_w_o), 128'(w_pat(0, 0)));
    adv();
    @(negedge clk);
    chk("rr_pending_empty", 128'(bus.w_pending_o), 128'd0);
    chk("rr_w_idle", 128'(bus.oup_w_valid_o), 128'd0);

    // Grant lock while downstream stalls, then reset mid-burst.
    do_reset();
    bus.inp_aw_valid_i = 4'b0100;
    @(negedge clk);
    chk("lock_valid", 128'(bus.oup_aw_valid_o), 128'd1);
    chk("lock_idx_c1", 128'(bus.oup_aw_idx_o), 128'd2);
    chk("lock_ready_c1", 128'(bus.inp_aw_ready_o), 128'd0);
    adv();
    bus.inp_aw_valid_i = 4'b0101;
    @(negedge clk);
    chk("lock_idx_c2", 128'(bus.oup_aw_idx_o), 128'd2);
    chk("lock_payload_c2", 128'(bus.oup_aw_o), 128'(aw_pat(2)));
    adv();
    @(negedge clk);
    chk("lock_idx_c3", 128'(bus.oup_aw_idx_o), 128'd2);
    adv();
    bus.oup_aw_ready_i = 1'b1;
    @(negedge clk);
    chk("lock_idx_hs", 128'(bus.oup_aw_idx_o), 128'd2);
    chk("lock_payload_hs", 128'(bus.oup_aw_o), 128'(aw_pat(2)));
    chk("lock_ready_hs", 128'(bus.inp_aw_ready_o), 128'b0100);
    adv();
    bus.inp_aw_valid_i = 4'b0001;
    @(negedge clk);
    chk("after_lock_idx", 128'(bus.oup_aw_idx_o), 128'd0);
    chk("after_lock_ready", 128'(bus.inp_aw_ready_o), 128'b0001);
    adv();
    bus.inp_aw_valid_i = '0;
    bus.oup_w_ready_i  = 1'b1;
    drive_w(4'b0100, 1'b0);
    @(negedge clk);
    chk("mid_pending", 128'(bus.w_pending_o), 128'd2);
    chk("mid_w_valid", 128'(bus.oup_w_valid_o), 128'd1);
    chk("mid_w_data", 128'(bus.oup_w_o), 128'(w_pat(2, 0)));
    chk("mid_w_ready", 128'(bus.inp_w_ready_o), 128'b0100);
    adv();
    bt[2] = 1;
    drive_w(4'b0100, 1'b0);
    @(negedge clk);
    chk("mid_no_pop", 128'(bus.w_pending_o), 128'd2);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    bus.oup_aw_ready_i = 1'b0;
    bus.inp_aw_valid_i = 4'b1011;
    @(negedge clk);
    chk("mrst_pending", 128'(bus.w_pending_o), 128'd0);
    chk("mrst_w_valid", 128'(bus.oup_w_valid_o), 128'd0);
    chk("mrst_w_ready", 128'(bus.inp_w_ready_o), 128'd0);
    chk("mrst_rr_idx", 128'(bus.oup_aw_idx_o), 128'd0);

    // Queue full stalls AW until one burst completes.
    do_reset();
    bus.inp_aw_valid_i = 4'b0001;
    bus.oup_aw_ready_i = 1'b1;
    bus.oup_w_ready_i  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fill_aw_ready", 128'(bus.inp_aw_ready_o), 128'b0001);
      adv();
    end
    @(negedge clk);
    chk("full_pending", 128'(bus.w_pending_o), 128'd4);
    chk("full_aw_valid", 128'(bus.oup_aw_valid_o), 128'd0);
    chk("full_aw_ready", 128'(bus.inp_aw_ready_o), 128'd0);
    drive_w(4'b0001, 1'b1);
    @(negedge clk);
    chk("full_w_valid", 128'(bus.oup_w_valid_o), 128'd1);
    chk("full_w_ready", 128'(bus.inp_w_ready_o), 128'b0001);
    adv();
    drive_w('0, 1'b1);
    @(negedge clk);
    chk("pop_pending", 128'(bus.w_pending_o), 128'd3);
    chk("pop_aw_valid", 128'(bus.oup_aw_valid_o), 128'd1);
    chk("pop_aw_ready", 128'(bus.inp_aw_ready_o), 128'b0001);
    adv();
    bus.inp_aw_valid_i = '0;
    @(negedge clk);
    chk("refill_pending", 128'(bus.w_pending_o), 128'd4);
    drive_w(4'b0001, 1'b1);
    for (int k = 0; k < 4; k++) adv();
    @(negedge clk);
    chk("drain_pending", 128'(bus.w_pending_o), 128'd0);

    // W bursts routed in AW order: input 1 fully before input 3.
    do_reset();
    bus.inp_aw_valid_i = 4'b0010;
    bus.oup_aw_ready_i = 1'b1;
    bus.oup_w_ready_i  = 1'b1;
    drive_w(4'b1010, 1'b0);
    @(negedge clk);
    chk("ord_idx1", 128'(bus.oup_aw_idx_o), 128'd1);
    chk("ord_w_not_yet", 128'(bus.oup_w_valid_o), 128'd0);
    adv();
    bus.inp_aw_valid_i = 4'b1000;
    @(negedge clk);
    chk("ord_idx3", 128'(bus.oup_aw_idx_o), 128'd3);
    chk("ord_w_next", 128'(bus.oup_w_valid_o), 128'd1);
    chk("ord_w_b0", 128'(bus.oup_w_o), 128'(w_pat(1, 0)));
    chk("ord_ready_b0", 128'(bus.inp_w_ready_o), 128'b0010);
    adv();
    bus.inp_aw_valid_i = '0;
    bt[1] = 1;
    drive_w(4'b1010, 1'b0);
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      chk("ord_in1_ready", 128'(bus.inp_w_ready_o), 128'b0010);
      chk("ord_in1_data", 128'(bus.oup_w_o), 128'(w_pat(1, b)));
      chk("ord_in1_last", 128'(bus.oup_w_last_o), 128'(b == 3));
      adv();
      bt[1]++;
      drive_w(4'b1010, 1'b0);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("ord_in3_ready", 128'(bus.inp_w_ready_o), 128'b1000);
      chk("ord_in3_data", 128'(bus.oup_w_o), 128'(w_pat(3, b)));
      chk("ord_in3_last", 128'(bus.oup_w_last_o), 128'(b == 3));
      adv();
      bt[3]++;
      drive_w(4'b1010, 1'b0);
    end
    @(negedge clk);
    chk("ord_pending", 128'(bus.w_pending_o), 128'd0);
    chk("ord_w_idle", 128'(bus.oup_w_valid_o), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
